// File: rtl/goldschmidt_pkg.sv
// Shared definitions for the Goldschmidt divider: FSM states, Q-format
// defaults and the product re-alignment used by the controller and multiplier wrapper.
package goldschmidt_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ITERS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_N,
    S_WAIT_N,
    S_MUL_D,
    S_WAIT_D,
    S_UPD,
    S_DONE
  } state_e;

  // 2.0 in Q2.(w-2): only the top bit set.
  function automatic logic [63:0] two_const(input int w);
    return 64'(1) << (w - 1);
  endfunction

  // Re-aligns a Q4.(2w-4) product to Q2.(w-2) by truncation: p[2w-3:w-2].
  function automatic logic [63:0] prod_slice(input logic [127:0] p, input int w);
    return 64'(p >> (w - 2));
  endfunction

endpackage

// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt iteration sequencer: owns the N/D/F working registers and
// time-shares one external multiplier through ITERS rounds per division.
module goldschmidt_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITERS = DEF_ITERS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_n,
  input  logic [WIDTH-1:0]     in_d,
  input  logic [WIDTH-1:0]     in_f0,
  output logic                 mul_req,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_ack,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_q,
  output logic                 div0,
  output logic                 busy
);

  localparam int ITW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [ITW-1:0]   LAST_ITER = ITW'(ITERS - 1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(two_const(WIDTH));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [ITW-1:0]   iter_q, iter_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] prod_w;

  assign prod_w = WIDTH'(prod_slice(128'(mul_p), WIDTH));
  assign div0   = div0_q;

  // NOTE: reset is synchronous, so it is tested inside the clocked block and
  // a mid-operation rst simply overrides whatever next state was computed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      f_q     <= '0;
      iter_q  <= '0;
      div0_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      f_q     <= f_d;
      iter_q  <= iter_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state signal gets a default first; any path
    // that skipped an assignment would otherwise infer a latch.
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    f_d       = f_q;
    iter_d    = iter_q;
    div0_d    = div0_q;
    in_ready  = 1'b0;
    mul_req   = 1'b0;
    out_valid = 1'b0;
    out_q     = '0;
    busy      = 1'b1;
    // Operands stay on the bus from the request through the wait state.
    mul_a     = (state_q == S_MUL_D || state_q == S_WAIT_D) ? d_q : n_q;
    mul_b     = f_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          n_d    = in_n;
          d_d    = in_d;
          f_d    = in_f0;
          iter_d = '0;
          div0_d = (in_d == '0);
          if (in_d == '0) begin
            n_d     = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_MUL_N;
          end
        end
      end
      S_MUL_N: begin
        mul_req = 1'b1;
        state_d = S_WAIT_N;
      end
      S_WAIT_N: begin
        if (mul_ack) begin
          n_d     = prod_w;
          state_d = S_MUL_D;
        end
      end
      S_MUL_D: begin
        mul_req = 1'b1;
        state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        if (mul_ack) begin
          d_d     = prod_w;
          state_d = S_UPD;
        end
      end
      S_UPD: begin
        f_d     = TWO - d_q;
        iter_d  = iter_q + ITW'(1);
        state_d = (iter_q == LAST_ITER) ? S_DONE : S_MUL_N;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_q     = n_q;
        if (out_ready) begin
          div0_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Self-checking bench for goldschmidt_ctrl: directed vector table, hand-written
// back-pressure and abort sequences, and randomized jobs against a reference model.
module tb_goldschmidt_ctrl;

  localparam int W  = 16;
  localparam int IT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_n, in_d, in_f0;
  logic           mul_req;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_ack;
  logic [2*W-1:0] mul_p;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_q;
  logic           div0;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  goldschmidt_ctrl #(.WIDTH(W), .ITERS(IT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .in_f0     (in_f0),
    .mul_req   (mul_req),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ack   (mul_ack),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .div0      (div0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Multiplier model: acks L cycles after the request cycle. Acts 2 time units
  // after each rising edge so it never races the bench's negedge stimulus.
  int          lat       = 1;
  int          req_cnt   = 0;
  bit          stray_ack = 1'b0;
  bit          mul_pend  = 1'b0;
  int          mul_cnt   = 0;
  logic [31:0] mul_prod  = '0;

  initial begin
    mul_ack = 1'b0;
    mul_p   = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_ack = 1'b0;
      if (rst) begin
        mul_pend = 1'b0;
      end else begin
        if (mul_pend) begin
          mul_cnt--;
          if (mul_cnt == 0) begin
            mul_ack  = 1'b1;
            mul_p    = mul_prod;
            mul_pend = 1'b0;
          end
        end
        if (mul_req) begin
          mul_pend = 1'b1;
          mul_cnt  = lat;
          mul_prod = 32'(mul_a) * 32'(mul_b);
          req_cnt++;
        end
      end
      if (stray_ack) begin
        mul_ack   = 1'b1;
        mul_p     = 32'h1234_5678;
        stray_ack = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_tol(input string name, input logic [15:0] act, input logic [15:0] exp,
                           input int tol);
    int diff;
    n_checks++;
    diff = int'(act) - int'(exp);
    if (diff < 0) diff = -diff;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, exp, tol);
  endtask

  // Reference: the Goldschmidt recurrence in plain integer arithmetic.
  function automatic logic [15:0] ref_div(input logic [15:0] n, input logic [15:0] d,
                                          input logic [15:0] f, output logic dz);
    longint nn, dd, ff;
    dz = (d == 0);
    if (d == 0) return 16'hFFFF;
    nn = longint'(n);
    dd = longint'(d);
    ff = longint'(f);
    for (int r = 0; r < IT; r++) begin
      nn = ((nn * ff) >> 14) % 65536;
      dd = ((dd * ff) >> 14) % 65536;
      ff = (32768 - dd + 65536) % 65536;
    end
    return 16'(nn);
  endfunction

  function automatic int ref_latency(input logic [15:0] d, input int l);
    return (d == 0) ? 1 : 1 + IT * (3 + 2 * l);
  endfunction

  task automatic start_job(input logic [15:0] n, input logic [15:0] d, input logic [15:0] f);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_job", 32'(in_ready), 32'd1);
    in_n     = n;
    in_d     = d;
    in_f0    = f;
    req_cnt  = 0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic complete_job(input int hold);
    for (int k = 0; k < hold; k++) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] n, input logic [15:0] d, input logic [15:0] f,
                         input int hold, output logic [15:0] q, output logic dz,
                         output int cyc, output int reqs, output bit ok);
    start_job(n, d, f);
    wait_done(cyc, ok);
    q    = out_q;
    dz   = div0;
    reqs = req_cnt;
    if (ok) complete_job(hold);
  endtask

  typedef struct {
    string       name;
    logic [15:0] n, d, f;
    int          l;
    logic [15:0] q;
    int          tol;
    logic        dz;
    int          cyc;
    int          reqs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] q, n, d, f, exp_q;
    logic        dz, exp_dz;
    int          cyc, reqs, hold;
    bit          ok;

    vecs[0] = '{"unity",      16'h4000, 16'h4000, 16'h4000, 1, 16'h4000, 0, 1'b0, 16, 6};
    vecs[1] = '{"q1p2_L1",    16'h6000, 16'h5000, 16'h3333, 1, 16'h4CCC, 2, 1'b0, 16, 6};
    vecs[2] = '{"div_zero",   16'h1234, 16'h0000, 16'h4000, 1, 16'hFFFF, 0, 1'b1, 1,  0};
    vecs[3] = '{"q1p2_L7",    16'h6000, 16'h5000, 16'h3333, 7, 16'h4CCC, 2, 1'b0, 52, 6};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_n      = '0;
    in_d      = '0;
    in_f0     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_mul_req",   32'(mul_req),   32'd0);
    check("reset_out_q",     32'(out_q),     32'd0);
    check("reset_div0",      32'(div0),      32'd0);

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].l;
      run_job(vecs[i].n, vecs[i].d, vecs[i].f, 0, q, dz, cyc, reqs, ok);
      if (ok) begin
        check_tol({vecs[i].name, "_q"}, q, vecs[i].q, vecs[i].tol);
        check({vecs[i].name, "_div0"},    32'(dz),   32'(vecs[i].dz));
        check({vecs[i].name, "_latency"}, 32'(cyc),  32'(vecs[i].cyc));
        check({vecs[i].name, "_mul_reqs"}, 32'(reqs), 32'(vecs[i].reqs));
      end
    end

    // Back-pressure in DONE: outputs hold, no capture of a new operand.
    lat = 1;
    start_job(16'h4000, 16'h4000, 16'h4000);
    wait_done(cyc, ok);
    if (ok) begin
      in_n     = 16'h2000;
      in_d     = 16'h0000;
      in_f0    = 16'h1111;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_q",     32'(out_q),     32'h4000);
        check("hold_div0",      32'(div0),      32'd0);
        check("hold_in_ready",  32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("after_hold_in_ready",  32'(in_ready),  32'd1);
      check("after_hold_busy",      32'(busy),      32'd0);
      check("after_hold_out_valid", 32'(out_valid), 32'd0);
    end

    // Reset in WAIT_D, then a stray ack while idle.
    lat = 3;
    start_job(16'h6000, 16'h5000, 16'h3333);
    cyc = 0;
    while (req_cnt < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_mul_d", 32'(req_cnt), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_mul_req",   32'(mul_req),   32'd0);
    check("abort_out_q",     32'(out_q),     32'd0);
    check("abort_div0",      32'(div0),      32'd0);
    check("abort_n_reg",     32'(mul_a),     32'd0);
    check("abort_f_reg",     32'(mul_b),     32'd0);

    lat = 1;
    run_job(16'h6000, 16'h5000, 16'h3333, 0, q, dz, cyc, reqs, ok);
    exp_q = ref_div(16'h6000, 16'h5000, 16'h3333, exp_dz);
    if (ok) begin
      check("post_abort_q",       32'(q),   32'(exp_q));
      check("post_abort_latency", 32'(cyc), 32'd16);
    end

    // Randomized jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      n = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       d = 16'h0000;
        1:       d = 16'($urandom_range(1, 16'hFFFF));
        default: d = 16'($urandom_range(16'h4000, 16'h7FFF));
      endcase
      if (d >= 16'h4000 && d < 16'h8000)
        f = 16'((32'h1000_0000 / 32'(d)) + 32'($urandom_range(0, 15)) - 32'd8);
      else
        f = 16'($urandom);
      lat  = $urandom_range(1, 5);
      hold = $urandom_range(0, 3);
      exp_q = ref_div(n, d, f, exp_dz);
      run_job(n, d, f, hold, q, dz, cyc, reqs, ok);
      if (ok) begin
        check($sformatf("rand%0d_q", j),        32'(q),    32'(exp_q));
        check($sformatf("rand%0d_div0", j),     32'(dz),   32'(exp_dz));
        check($sformatf("rand%0d_latency", j),  32'(cyc),  32'(ref_latency(d, lat)));
        check($sformatf("rand%0d_mul_reqs", j), 32'(reqs), (d == 0) ? 32'd0 : 32'(2 * IT));
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
